// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command host: command codes, image geometry, FSM states.
// No logic; latency and backpressure are defined by the modules that import it.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE = 4'h0;
    localparam logic [3:0] CMD_UP    = 4'h1;
    localparam logic [3:0] CMD_DOWN  = 4'h2;
    localparam logic [3:0] CMD_LEFT  = 4'h3;
    localparam logic [3:0] CMD_RIGHT = 4'h4;
    localparam logic [3:0] CMD_MAX   = 4'h5;
    localparam logic [3:0] CMD_MIN   = 4'h6;
    localparam logic [3:0] CMD_AVG   = 4'h7;
    localparam logic [3:0] CMD_CCW   = 4'h8;
    localparam logic [3:0] CMD_CW    = 4'h9;
    localparam logic [3:0] CMD_MX    = 4'hA;
    localparam logic [3:0] CMD_MY    = 4'hB;

    localparam int IMG_W   = 8;
    localparam int IMG_PIX = 64;
    localparam int CMD_W   = 4;
    localparam int PIX_W   = 8;
    localparam int ADDR_W  = 6;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } host_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  dat;
    } iram_wr_t;

    function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
        return c <= CMD_MY;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; head visible combinationally, push/pop take effect on the next edge.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/lcd_cmd_host.sv
// Queues LCD commands, issues them to the controller over cmd_valid/busy, shadows IRAM writes.
// Issue 2 cycles after push when idle; rd_data 1 cycle; host_cmd_full drops pushes while full.
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  host_cmd,
    input  logic              host_cmd_push,
    output logic              host_cmd_full,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    input  logic              IRAM_valid,
    input  logic [PIX_W-1:0]  IRAM_D,
    input  logic [ADDR_W-1:0] IRAM_A,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic [7:0]        cmds_done,
    output logic [6:0]        wr_count,
    output logic              err_timeout,
    output logic              idle
);

    localparam int TW = $clog2(TIMEOUT + 1);

    host_state_t      state;
    host_state_t      state_nxt;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             cmd_finish;
    logic             tmo_fire;
    logic             tmo_hit;
    logic [TW-1:0]    tmo_cnt;
    logic [PIX_W-1:0] shadow [IMG_PIX];
    iram_wr_t         wr;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (host_cmd_push),
        .push_dat (host_cmd),
        .pop      (state == ST_ISSUE),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign host_cmd_full = fifo_full;
    assign idle          = (state == ST_IDLE) && fifo_empty;
    assign tmo_hit       = (tmo_cnt == TW'(TIMEOUT));
    assign wr            = '{addr: IRAM_A, dat: IRAM_D};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_finish = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            // After reset the controller reloads its image; wait for it to go quiet.
            ST_INIT:      if (!busy) state_nxt = ST_IDLE;
            ST_IDLE:      if (!fifo_empty && !busy) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy || done) begin
                    cmd_finish = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default:      state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            cmds_done   <= '0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
            wr_count    <= '0;
            rd_data     <= '0;
        end else begin
            // cmd_valid is high exactly during the ISSUE cycle; cmd holds until the next issue.
            cmd_valid <= (state_nxt == ST_ISSUE);
            if (state_nxt == ST_ISSUE) cmd <= fifo_head;
            if (cmd_finish) cmds_done <= cmds_done + 8'd1;
            if (tmo_fire) err_timeout <= 1'b1;
            tmo_cnt <= (state_nxt != state) ? '0 : tmo_cnt + TW'(1);
            // A write landing in the ISSUE cycle already belongs to the new command.
            if (state == ST_ISSUE)
                wr_count <= IRAM_valid ? 7'd1 : 7'd0;
            else if (IRAM_valid && wr_count != 7'd127)
                wr_count <= wr_count + 7'd1;
            rd_data <= shadow[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (IRAM_valid) shadow[wr.addr] <= wr.dat;
    end

endmodule
